byte_pair_packer: RTL and testbench

Upstream feeder for the 2 × 8-bit register set. It collects a byte stream arriving under a valid/ready handshake into byte pairs. It presents each pair on `d1`/`d2` with a valid/ready handshake to the downstream register stage. Odd-length bursts are closed with a pad byte, and the block keeps a count of delivered pairs.

---
 rtl/byte_pair_packer.sv | 116 +++++++++++
 tb/tb_byte_pair_packer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_pair_packer.sv
// Byte stream to byte-pair packer with valid/ready on both sides.
// Odd bursts are closed with PAD; completed output handshakes are counted.
//
// state | meaning
// EMPTY | no byte held
// HALF  | d1 loaded, waiting for second byte
// FULL  | pair presented on d1/d2
module byte_pair_packer #(
   parameter logic [7:0] PAD = 8'h00
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_in_data,
   input  logic        i_in_valid,
   input  logic        i_in_last,
   output logic        o_in_ready,
   output logic [7:0]  o_d1,
   output logic [7:0]  o_d2,
   output logic        o_out_odd,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [15:0] o_pair_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      r_state;
   logic [7:0]  r_d1;
   logic [7:0]  r_d2;
   logic        r_odd;
   logic [15:0] r_cnt;

   state_t      w_state_nxt;
   logic [7:0]  w_d1_nxt;
   logic [7:0]  w_d2_nxt;
   logic        w_odd_nxt;
   logic        w_in_acc;
   logic        w_out_acc;

   assign o_out_valid  = (r_state == FULL);
   assign o_in_ready   = (r_state != FULL) | i_out_ready;
   assign w_in_acc     = i_in_valid & o_in_ready;
   assign w_out_acc    = o_out_valid & i_out_ready;
   assign o_d1         = r_d1;
   assign o_d2         = r_d2;
   assign o_out_odd    = r_odd;
   assign o_pair_count = r_cnt;

   always_comb begin
      w_state_nxt = r_state;
      w_d1_nxt    = r_d1;
      w_d2_nxt    = r_d2;
      w_odd_nxt   = r_odd;
      case (r_state)
         EMPTY: begin
            if (w_in_acc) begin
               w_d1_nxt = i_in_data;
               if (i_in_last) begin
                  w_d2_nxt    = PAD;
                  w_odd_nxt   = 1'b1;
                  w_state_nxt = FULL;
               end else begin
                  w_state_nxt = HALF;
               end
            end
         end
         HALF: begin
            // in_last is irrelevant here: the pair closes either way
            if (w_in_acc) begin
               w_d2_nxt    = i_in_data;
               w_odd_nxt   = 1'b0;
               w_state_nxt = FULL;
            end
         end
         FULL: begin
            if (w_out_acc) begin
               if (w_in_acc) begin
                  w_d1_nxt = i_in_data;
                  if (i_in_last) begin
                     w_d2_nxt    = PAD;
                     w_odd_nxt   = 1'b1;
                     w_state_nxt = FULL;
                  end else begin
                     w_state_nxt = HALF;
                  end
               end else begin
                  w_state_nxt = EMPTY;
               end
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= EMPTY;
         r_d1    <= 8'h00;
         r_d2    <= 8'h00;
         r_odd   <= 1'b0;
         r_cnt   <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         r_d1    <= w_d1_nxt;
         r_d2    <= w_d2_nxt;
         r_odd   <= w_odd_nxt;
         if (w_out_acc)
            r_cnt <= r_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_byte_pair_packer.sv
// Directed bench for byte_pair_packer: reset, even/odd bursts, backpressure,
// streaming, reset mid-pair and pair counter wrap.
module tb_byte_pair_packer;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [7:0]  d1;
   logic [7:0]  d2;
   logic        out_odd;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] pair_count;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_cnt;

   byte_pair_packer #(.PAD(8'h5A)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_in_data    (in_data),
      .i_in_valid   (in_valid),
      .i_in_last    (in_last),
      .o_in_ready   (in_ready),
      .o_d1         (d1),
      .o_d2         (d2),
      .o_out_odd    (out_odd),
      .o_out_valid  (out_valid),
      .i_out_ready  (out_ready),
      .o_pair_count (pair_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      // Put some non-reset state in place: one counted pair, then HALF with d1=C3.
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hE1; in_last = 1'b1;
      tick();
      in_data = 8'hC3; in_last = 1'b0;
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || d1 !== 8'h00 || d2 !== 8'h00 || pair_count !== 16'h0000 || out_odd !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: valid=%b d1=%h d2=%h odd=%b cnt=%h, required 0/00/00/0/0000",
                  out_valid, d1, d2, out_odd, pair_count);
      end
      #2;
      rst_n = 1'b1;
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
      exp_cnt = 16'h0000;
   endtask

   task automatic test_even_burst();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h12; in_last = 1'b0;
      tick();
      in_data = 8'h34; in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || d1 !== 8'h12 || d2 !== 8'h34 || out_odd !== 1'b0) begin
         errors++;
         $display("FAIL even_pair: valid=%b d1=%h d2=%h odd=%b, required 1/12/34/0",
                  out_valid, d1, d2, out_odd);
      end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if (pair_count !== exp_cnt || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL even_count: cnt=%h valid=%b, required %h/0", pair_count, out_valid, exp_cnt);
      end
   endtask

   task automatic test_odd_burst();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'hAB; in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || d1 !== 8'hAB || d2 !== 8'h5A || out_odd !== 1'b1) begin
         errors++;
         $display("FAIL odd_pair: valid=%b d1=%h d2=%h odd=%b, required 1/ab/5a/1",
                  out_valid, d1, d2, out_odd);
      end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if (pair_count !== exp_cnt) begin
         errors++;
         $display("FAIL odd_count: cnt=%h required %h", pair_count, exp_cnt);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
      tick();
      in_data = 8'h02; in_last = 1'b1;
      tick();
      in_data = 8'h03; in_last = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready cycle %0d: got %b required 0", c, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || d1 !== 8'h01 || d2 !== 8'h02 || out_odd !== 1'b0 || pair_count !== exp_cnt) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: valid=%b d1=%h d2=%h odd=%b cnt=%h, required 1/01/02/0/%h",
                     c, out_valid, d1, d2, out_odd, pair_count, exp_cnt);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: got %b required 1", in_ready);
      end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if (out_valid !== 1'b0 || d1 !== 8'h03 || pair_count !== exp_cnt) begin
         errors++;
         $display("FAIL bp_release: valid=%b d1=%h cnt=%h, required 0/03/%h", out_valid, d1, pair_count, exp_cnt);
      end
      in_data = 8'h04; in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || d1 !== 8'h03 || d2 !== 8'h04 || out_odd !== 1'b0) begin
         errors++;
         $display("FAIL bp_next_pair: valid=%b d1=%h d2=%h odd=%b, required 1/03/04/0",
                  out_valid, d1, d2, out_odd);
      end
      tick();
      exp_cnt = exp_cnt + 16'd1;
   endtask

   task automatic test_streaming();
      int pairs;
      pairs = 0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(i);
         in_last = (i == 15);
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready byte %0d: got %b required 1", i, in_ready);
         end
         tick();
         checks++;
         if ((i % 2) == 1) begin
            if (out_valid !== 1'b1 || d1 !== 8'(i - 1) || d2 !== 8'(i) || out_odd !== 1'b0) begin
               errors++;
               $display("FAIL stream_pair %0d: valid=%b d1=%h d2=%h, required 1/%h/%h",
                        i / 2, out_valid, d1, d2, 8'(i - 1), 8'(i));
            end else begin
               pairs++;
            end
         end else if (out_valid !== 1'b0 || d1 !== 8'(i)) begin
            errors++;
            $display("FAIL stream_half byte %0d: valid=%b d1=%h, required 0/%h", i, out_valid, d1, 8'(i));
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      exp_cnt = exp_cnt + 16'd8;
      checks++;
      if (pairs != 8 || pair_count !== exp_cnt || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_total: pairs=%0d cnt=%h valid=%b, required 8/%h/0", pairs, pair_count, out_valid, exp_cnt);
      end
   endtask

   task automatic test_reset_half_and_wrap();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h77; in_last = 1'b0;
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      exp_cnt = 16'h0000;
      tick();
      in_valid = 1'b1; in_data = 8'h88; in_last = 1'b0;
      tick();
      in_data = 8'h99; in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || d1 !== 8'h88 || d2 !== 8'h99 || out_odd !== 1'b0 || pair_count !== 16'h0000) begin
         errors++;
         $display("FAIL reset_half_pair: valid=%b d1=%h d2=%h odd=%b cnt=%h, required 1/88/99/0/0000",
                  out_valid, d1, d2, out_odd, pair_count);
      end
      tick();
      // count is 1; one load tick plus 0xFFFE back-to-back odd pairs reaches 0xFFFF
      in_valid = 1'b1; in_last = 1'b1;
      for (int i = 0; i < 32'h0000_FFFF; i++) begin
         in_data = 8'(i);
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (pair_count !== 16'hFFFF || out_valid !== 1'b1 || out_odd !== 1'b1) begin
         errors++;
         $display("FAIL wrap_preload: cnt=%h valid=%b odd=%b, required ffff/1/1", pair_count, out_valid, out_odd);
      end
      tick();
      checks++;
      if (pair_count !== 16'h0000 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL wrap: cnt=%h valid=%b, required 0000/0", pair_count, out_valid);
      end
   endtask

   initial begin
      exp_cnt = 16'h0000;
      test_reset();
      test_even_burst();
      test_odd_burst();
      test_backpressure();
      test_streaming();
      test_reset_half_and_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
